// File: rtl/la32_enc_pkg.sv
// Shared types and constants for the LA32R micro-op encoder and its writer.
package la32_enc_pkg;

    // Decoded micro-op selector; 34 entries, so 6 bits wide.
    typedef enum logic [5:0] {
        OpAdd, OpSub, OpSlt, OpSltu, OpNor, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra,
        OpMul, OpDiv, OpSlli, OpSrli, OpSrai, OpSlti, OpSltui, OpAddi, OpAndi, OpOri,
        OpXori, OpLu12i, OpLdw, OpStw, OpJirl, OpB, OpBl, OpBeq, OpBne, OpBlt, OpBge,
        OpBltu, OpBgeu
    } op_e;

    // Instruction formats, including the two flavours of 12-bit immediate.
    typedef enum logic [2:0] {
        Fmt3r, Fmt2ri5, Fmt2ri12s, Fmt2ri12u, Fmt2ri16, FmtI26, Fmt1ri20, FmtBad
    } fmt_e;

    // Writer FSM states.
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    // Emitted in place of anything that cannot be encoded.
    localparam logic [31:0] BreakWord = 32'h002A_0000;

    localparam logic [31:0] OpcAdd   = 32'h0010_0000;
    localparam logic [31:0] OpcSub   = 32'h0011_0000;
    localparam logic [31:0] OpcSlt   = 32'h0012_0000;
    localparam logic [31:0] OpcSltu  = 32'h0012_8000;
    localparam logic [31:0] OpcNor   = 32'h0014_0000;
    localparam logic [31:0] OpcAnd   = 32'h0014_8000;
    localparam logic [31:0] OpcOr    = 32'h0015_0000;
    localparam logic [31:0] OpcXor   = 32'h0015_8000;
    localparam logic [31:0] OpcSll   = 32'h0017_0000;
    localparam logic [31:0] OpcSrl   = 32'h0017_8000;
    localparam logic [31:0] OpcSra   = 32'h0018_0000;
    localparam logic [31:0] OpcMul   = 32'h001C_0000;
    localparam logic [31:0] OpcDiv   = 32'h0020_0000;
    localparam logic [31:0] OpcSlli  = 32'h0040_8000;
    localparam logic [31:0] OpcSrli  = 32'h0044_8000;
    localparam logic [31:0] OpcSrai  = 32'h0048_8000;
    localparam logic [31:0] OpcSlti  = 32'h0200_0000;
    localparam logic [31:0] OpcSltui = 32'h0240_0000;
    localparam logic [31:0] OpcAddi  = 32'h0280_0000;
    localparam logic [31:0] OpcAndi  = 32'h0340_0000;
    localparam logic [31:0] OpcOri   = 32'h0380_0000;
    localparam logic [31:0] OpcXori  = 32'h03C0_0000;
    localparam logic [31:0] OpcLu12i = 32'h1400_0000;
    localparam logic [31:0] OpcLdw   = 32'h2880_0000;
    localparam logic [31:0] OpcStw   = 32'h2980_0000;
    localparam logic [31:0] OpcJirl  = 32'h4C00_0000;
    localparam logic [31:0] OpcB     = 32'h5000_0000;
    localparam logic [31:0] OpcBl    = 32'h5400_0000;
    localparam logic [31:0] OpcBeq   = 32'h5800_0000;
    localparam logic [31:0] OpcBne   = 32'h5C00_0000;
    localparam logic [31:0] OpcBlt   = 32'h6000_0000;
    localparam logic [31:0] OpcBge   = 32'h6400_0000;
    localparam logic [31:0] OpcBltu  = 32'h6800_0000;
    localparam logic [31:0] OpcBgeu  = 32'h6C00_0000;

    function automatic fmt_e op_format(input logic [5:0] op);
        case (op)
            OpAdd, OpSub, OpSlt, OpSltu, OpNor, OpAnd, OpOr, OpXor,
            OpSll, OpSrl, OpSra, OpMul, OpDiv:              return Fmt3r;
            OpSlli, OpSrli, OpSrai:                         return Fmt2ri5;
            OpSlti, OpSltui, OpAddi, OpLdw, OpStw:          return Fmt2ri12s;
            OpAndi, OpOri, OpXori:                          return Fmt2ri12u;
            OpJirl, OpBeq, OpBne, OpBlt, OpBge, OpBltu,
            OpBgeu:                                         return Fmt2ri16;
            OpB, OpBl:                                      return FmtI26;
            OpLu12i:                                        return Fmt1ri20;
            default:                                        return FmtBad;
        endcase
    endfunction

    function automatic logic [31:0] base_opcode(input logic [5:0] op);
        case (op)
            OpAdd:   return OpcAdd;
            OpSub:   return OpcSub;
            OpSlt:   return OpcSlt;
            OpSltu:  return OpcSltu;
            OpNor:   return OpcNor;
            OpAnd:   return OpcAnd;
            OpOr:    return OpcOr;
            OpXor:   return OpcXor;
            OpSll:   return OpcSll;
            OpSrl:   return OpcSrl;
            OpSra:   return OpcSra;
            OpMul:   return OpcMul;
            OpDiv:   return OpcDiv;
            OpSlli:  return OpcSlli;
            OpSrli:  return OpcSrli;
            OpSrai:  return OpcSrai;
            OpSlti:  return OpcSlti;
            OpSltui: return OpcSltui;
            OpAddi:  return OpcAddi;
            OpAndi:  return OpcAndi;
            OpOri:   return OpcOri;
            OpXori:  return OpcXori;
            OpLu12i: return OpcLu12i;
            OpLdw:   return OpcLdw;
            OpStw:   return OpcStw;
            OpJirl:  return OpcJirl;
            OpB:     return OpcB;
            OpBl:    return OpcBl;
            OpBeq:   return OpcBeq;
            OpBne:   return OpcBne;
            OpBlt:   return OpcBlt;
            OpBge:   return OpcBge;
            OpBltu:  return OpcBltu;
            OpBgeu:  return OpcBgeu;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/la32_encode.sv
// Combinational LA32R encoder: one decoded micro-op in, one instruction word out.
module la32_encode
    import la32_enc_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rj,
    input  logic [4:0]  rk,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_err
);

    fmt_e        fmt;
    logic [31:0] base;
    logic        u5_ok, u12_ok, s12_ok, s16_ok, s20_ok, s26_ok;

    // A value fits an n-bit signed field when bits [31:n-1] are all equal.
    assign u5_ok  = ~(|imm[31:5]);
    assign u12_ok = ~(|imm[31:12]);
    assign s12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign s16_ok = (&imm[31:15]) | ~(|imm[31:15]);
    assign s20_ok = (&imm[31:19]) | ~(|imm[31:19]);
    assign s26_ok = (&imm[31:25]) | ~(|imm[31:25]);

    // Field packing per format; anything unencodable collapses to BREAK 0.
    // B/BL carry no rd field: the link register of BL is implicit (r1), B links nothing.
    always_comb begin
        fmt       = op_format(op);
        base      = base_opcode(op);
        word      = '0;
        range_err = 1'b0;
        case (fmt)
            Fmt3r: begin
                word = base | {17'd0, rk, rj, rd};
            end
            Fmt2ri5: begin
                range_err = ~u5_ok;
                word      = base | {17'd0, imm[4:0], rj, rd};
            end
            Fmt2ri12s: begin
                range_err = ~s12_ok;
                word      = base | {10'd0, imm[11:0], rj, rd};
            end
            Fmt2ri12u: begin
                range_err = ~u12_ok;
                word      = base | {10'd0, imm[11:0], rj, rd};
            end
            Fmt2ri16: begin
                // Branches: rd is the second compare source, same slot as JIRL's rd.
                range_err = ~s16_ok;
                word      = base | {6'd0, imm[15:0], rj, rd};
            end
            FmtI26: begin
                range_err = ~s26_ok;
                word      = base | {6'd0, imm[15:0], imm[25:16]};
            end
            Fmt1ri20: begin
                range_err = ~s20_ok;
                word      = base | {7'd0, imm[19:0], rd};
            end
            default: begin
                range_err = 1'b1;
            end
        endcase
        if (range_err) begin
            word = BreakWord;
        end
    end

endmodule

// File: rtl/instr_encoder_writer.sv
// Encodes a stream of micro-ops and writes the words sequentially into instruction memory.
module instr_encoder_writer
    import la32_enc_pkg::*;
#(
    parameter int unsigned   DEPTH     = 4,
    parameter int unsigned   AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [5:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rj,
    input  logic [4:0]    in_rk,
    input  logic [31:0]   in_imm,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   word_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    state_e        state_q, state_d;
    logic          start_ok, accept, push, pop, fifo_empty, fifo_full;
    logic [31:0]   enc_word;
    logic          enc_err;
    logic          enc_valid_q;
    logic [31:0]   enc_word_q;
    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, occ;
    logic [AW-1:0] addr_q;
    logic [15:0]   word_cnt_q;
    logic          err_q;

    la32_encode u_encode (
        .op        (in_op),
        .rd        (in_rd),
        .rj        (in_rj),
        .rk        (in_rk),
        .imm       (in_imm),
        .word      (enc_word),
        .range_err (enc_err)
    );

    assign start_ok   = start & (state_q == StIdle);
    assign accept     = in_valid & in_ready;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(DEPTH));
    // Encode stage counts as one more slot, so DEPTH+1 words can be in flight.
    assign occ        = cnt_q + CW'(enc_valid_q);
    assign pop        = ~fifo_empty & imem_ready;
    // A full FIFO still takes the encode stage when the head leaves this cycle.
    assign push       = enc_valid_q & (~fifo_full | pop);

    assign imem_we    = ~fifo_empty;
    assign imem_wdata = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_q];
    assign imem_addr  = addr_q;
    assign err        = err_q;
    assign word_cnt   = word_cnt_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; start is only honoured in idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (accept && in_last) state_d = StDrain;
            StDrain: if (!enc_valid_q && fifo_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        in_ready = (state_q == StRun) && (occ <= CW'(DEPTH));
    end

    // Encode stage: holds one word until the FIFO can take it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            enc_valid_q <= 1'b0;
            enc_word_q  <= '0;
        end else if (accept) begin
            enc_valid_q <= 1'b1;
            enc_word_q  <= enc_word;
        end else if (push) begin
            enc_valid_q <= 1'b0;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= enc_word_q;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Write address, saturating word count and sticky error, all cleared by start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q     <= BASE_ADDR;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (start_ok) begin
            addr_q     <= BASE_ADDR;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (pop) begin
                addr_q <= addr_q + AW'(4);
                if (word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (accept && enc_err) err_q <= 1'b1;
        end
    end

endmodule
